// File: rtl/vdp_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vdp_bus_pkg
//  Brief    : Shared types for the host-to-VDP bus bridge (FSM states,
//             queued write record, VDP address width and address helper).
//  Revision : 1.0  initial release
// ============================================================================
package vdp_bus_pkg;

    localparam int VDP_ADR_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4
    } bridge_state_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] data;
    } bus_req_t;

    // The host port select maps onto the low two address bits only.
    function automatic logic [VDP_ADR_W-1:0] mode_to_adr(input logic [1:0] m);
        return {{(VDP_ADR_W-2){1'b0}}, m};
    endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_filter.sv
`default_nettype none
// ============================================================================
//  Module   : strobe_filter
//  Brief    : Two-flop synchroniser, FILTER_LEN-sample glitch filter and
//             falling-edge pulse for one active-low host strobe.
//  Revision : 1.0  initial release
// ============================================================================
module strobe_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe_n,
    output logic filt_n,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_filt;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous strobe into the clk domain (idle level is high).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= strobe_n;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive synced samples that disagree with the filtered level;
    // the FILTER_LEN-th one flips the level and, on a fall, fires the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt <= 1'b1;
            r_fall <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_fall <= 1'b0;
            if (r_sync2 != r_filt) begin
                if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
                    r_filt <= r_sync2;
                    r_fall <= ~r_sync2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign filt_n = r_filt;
    assign fall   = r_fall;

endmodule
`default_nettype wire

// File: rtl/cpu_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_bridge
//  Brief    : Host-side front end of the VDP. Filters host strobes, queues
//             writes, and sequences writes/reads onto the VDP core port
//             under a REQ/ACK handshake with a timeout.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_bus_bridge
    import vdp_bus_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 csw_n,
    input  logic                 csr_n,
    input  logic [1:0]           mode,
    input  logic [7:0]           cd_in,
    output logic [7:0]           cd_out,
    output logic                 cd_oe,
    output logic                 vdp_req,
    output logic                 vdp_wrt,
    output logic [VDP_ADR_W-1:0] vdp_adr,
    output logic [7:0]           vdp_dbo,
    input  logic                 vdp_ack,
    input  logic [7:0]           vdp_dbi,
    output logic                 busy,
    output logic                 fifo_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    // ------------------------------------------------------------------------
    // Strobe conditioning
    // ------------------------------------------------------------------------
    logic w_wr_filt_n, w_wr_fall;
    logic w_rd_filt_n, w_rd_fall;

    strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_wr_filt (
        .clk      (clk),
        .reset    (reset),
        .strobe_n (csw_n),
        .filt_n   (w_wr_filt_n),
        .fall     (w_wr_fall)
    );

    strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_rd_filt (
        .clk      (clk),
        .reset    (reset),
        .strobe_n (csr_n),
        .filt_n   (w_rd_filt_n),
        .fall     (w_rd_fall)
    );

    // A strobe edge only counts while the other filtered strobe is idle, so
    // both strobes low together never produce an access.
    logic w_wr_event, w_rd_event;
    assign w_wr_event = w_wr_fall & w_rd_filt_n;
    assign w_rd_event = w_rd_fall & w_wr_filt_n;

    // ------------------------------------------------------------------------
    // Write queue
    // ------------------------------------------------------------------------
    bus_req_t        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    bridge_state_t r_state;
    bridge_state_t w_state_next;

    logic     w_full, w_empty, w_push, w_pop;
    bus_req_t w_head;

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = w_wr_event & ~w_full;
    assign w_pop   = (r_state == WR_REQ);
    assign w_head  = r_mem[r_rd_ptr];

    // Queue storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus_req_t'({mode, cd_in});
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_wr_event && w_full) r_ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Pending read
    // ------------------------------------------------------------------------
    logic       r_rd_pend;
    logic [1:0] r_rd_mode;
    logic       w_rd_accept;

    // A read arriving while one is still pending merges into it, except in
    // RD_REQ where the pending one is already being issued.
    assign w_rd_accept = w_rd_event & (~r_rd_pend | (r_state == RD_REQ));

    // Track the single outstanding host read and the port it addressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_rd_mode <= 2'b00;
        end else if (w_rd_accept) begin
            r_rd_pend <= 1'b1;
            r_rd_mode <= mode;
        end else if (r_state == RD_REQ) begin
            r_rd_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Access sequencer
    // ------------------------------------------------------------------------
    logic [TMR_W-1:0] r_timer;
    logic             w_tmr_expired;

    assign w_tmr_expired = (r_timer == TMR_W'(ACK_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: queued writes drain before a pending read to keep host order.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (!w_empty)       w_state_next = WR_REQ;
                else if (r_rd_pend) w_state_next = RD_REQ;
            end
            WR_REQ:  w_state_next = WR_WAIT;
            RD_REQ:  w_state_next = RD_WAIT;
            WR_WAIT,
            RD_WAIT: begin
                if (vdp_ack || w_tmr_expired) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Wait timer: zeroed in the request cycle, counts every wait cycle, so a
    // wait state lasts at most ACK_TIMEOUT cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_state == WR_REQ || r_state == RD_REQ) begin
            r_timer <= '0;
        end else if (r_state == WR_WAIT || r_state == RD_WAIT) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // VDP port and host read data
    // ------------------------------------------------------------------------
    logic                 r_req, r_wrt, r_cd_oe;
    logic [VDP_ADR_W-1:0] r_adr;
    logic [7:0]           r_dbo, r_cd_out;

    // Request is high exactly while in a REQ state; address/data/direction are
    // loaded on entry and held through the wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req <= 1'b0;
            r_wrt <= 1'b0;
            r_adr <= '0;
            r_dbo <= 8'h00;
        end else begin
            r_req <= (w_state_next == WR_REQ) || (w_state_next == RD_REQ);
            if (r_state == IDLE && w_state_next == WR_REQ) begin
                r_wrt <= 1'b1;
                r_adr <= mode_to_adr(w_head.mode);
                r_dbo <= w_head.data;
            end else if (r_state == IDLE && w_state_next == RD_REQ) begin
                r_wrt <= 1'b0;
                r_adr <= mode_to_adr(r_rd_mode);
            end
        end
    end

    // Host-facing read byte and drive enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cd_out <= 8'h00;
            r_cd_oe  <= 1'b0;
        end else begin
            r_cd_oe <= ~w_rd_filt_n;
            if (r_state == RD_WAIT && vdp_ack) r_cd_out <= vdp_dbi;
        end
    end

    assign vdp_req  = r_req;
    assign vdp_wrt  = r_wrt;
    assign vdp_adr  = r_adr;
    assign vdp_dbo  = r_dbo;
    assign cd_out   = r_cd_out;
    assign cd_oe    = r_cd_oe;
    assign fifo_ovf = r_ovf;
    assign busy     = ~w_empty | r_rd_pend | (r_state != IDLE);

endmodule
`default_nettype wire
